mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the 16-bit, 4-bit-opcode datapath (PC, instr mem, 16x16 reg file,
//  ALU, data mem, BNE mux). Splits each instruction into FETCH/DECODE/EXEC/MEM/WB cycles and
//  drives every datapath enable and mux select. Handshakes with a variable-latency data memory.
//  Replaces the combinational control decode when the core runs multi-cycle.
// PARAMETERS
//  OPW          4   opcode width (Instr[15:12])
//  MEM_WAIT_MAX 15  max cycles mem_req may wait for mem_ack before ERROR
//  CNT_W        16  perf-counter width (used only with MC_PERF_CNT_EN)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      reset: synchronous, active-low
//  opcode     in   OPW    Instr[15:12] from the instruction register
//  eq         in   1      ALU equal flag (valid in EXEC)
//  mem_ack    in   1      data-mem completion; sampled only while mem_req=1
//  ir_we      out  1      load instruction register
//  pc_we      out  1      load PC from branch mux
//  pc_src     out  1      0: PC+1, 1: PC+1+signext(Instr[3:0])
//  reg_dst    out  1      0: write addr Instr[7:4], 1: Instr[3:0]
//  reg_write  out  1      reg-file write enable
//  alu_src    out  1      0: R2, 1: sign-extended offset
//  mem_req    out  1      data-mem request, held until mem_ack
//  mem_write  out  1      1 store / 0 load, stable while mem_req=1
//  mem_to_reg out  1      0: ALU result, 1: mem read data
//  halted     out  1      HALT retired (sticky until reset)
//  err        out  1      illegal opcode or mem timeout (sticky until reset)
//  cyc_cnt    out  CNT_W  cycles since reset (perf)
//  ret_cnt    out  CNT_W  instructions retired (perf)
// BEHAVIOUR
//  - Opcodes: 0x0-0x7 R-type ALU, 0x8 LW, 0x9 SW, 0xA ADDI, 0xB BNE, 0xF HALT, 0xC-0xE illegal.
//  - States: FETCH->DECODE->EXEC->{WB|MEM|FETCH}; MEM->{WB|FETCH}; HALT, ERROR terminal.
//  - FETCH: ir_we=1, 1 cycle. DECODE: all outputs 0; illegal opcode -> ERROR.
//  - EXEC: alu_src=1 for LW/SW/ADDI, 0 otherwise. BNE: pc_we=1, pc_src=~eq, ->FETCH.
//    LW/SW -> MEM; R-type/ADDI -> WB; HALT -> HALT (pc_we=0, halted=1 next cycle).
//  - MEM: mem_req=1, mem_write=(SW), alu_src=1 held; wait counter starts at 0 on entry.
//    mem_ack=1: LW -> WB; SW: pc_we=1, pc_src=0, ->FETCH. Counter reaches MEM_WAIT_MAX
//    without ack -> ERROR, mem_req drops. ack on the same cycle as limit: ack wins.
//  - WB: reg_write=1, pc_we=1, pc_src=0; reg_dst=1 for R-type, 0 for LW/ADDI;
//    mem_to_reg=1 for LW only. ->FETCH.
//  - Latency: BNE 3, R/ADDI 4, SW 4+wait, LW 5+wait cycles (wait = cycles until ack, min 0).
//  - PC changes only in the instruction's final cycle: never mid-instruction.
//  - mem_ack outside MEM ignored. All outputs registered-state decoded, glitch-free.
//  - Reset (any state, incl. MEM mid-wait): next state FETCH; all outputs 0, halted=0,
//    err=0, counters 0; an outstanding mem_req is abandoned (memory must tolerate drop).
//  - HALT/ERROR: all enables 0 forever; only rst_n exits.
// CONFIGURATION
//  - MC_PERF_CNT_EN defined: cyc_cnt +1 every cycle out of reset, ret_cnt +1 on each cycle
//    with pc_we=1 or entry to HALT; both saturate at all-ones (no wrap); frozen in ERROR.
//  - Not defined: counter logic absent, cyc_cnt/ret_cnt tied to 0; ports remain.
// STRUCTURE
//  - Package mc_ctrl_pkg: state enum (FETCH,DECODE,EXEC,MEM,WB,HALT,ERROR), opcode
//    constants (OP_LW, OP_SW, OP_ADDI, OP_BNE, OP_HALT), is_rtype/is_illegal functions.
//  - Sub-module mc_perf_cnt (saturating counter pair), instantiated only under MC_PERF_CNT_EN.
//  - Top: state reg, wait counter, output decode.
// TESTING
//  - R-type 0x1 after reset: ir_we cyc1, WB cyc4 with reg_write=1, reg_dst=1, pc_we=1, pc_src=0.
//  - BNE eq=0: pc_we=1, pc_src=1 in cyc3; eq=1: pc_we=1, pc_src=0; no reg_write.
//  - LW, mem_ack after 3 cycles: mem_req high 4 cycles, mem_write=0, WB mem_to_reg=1, reg_dst=0.
//  - SW, ack never: mem_req high 16 cycles (MEM_WAIT_MAX+1), then err=1, all enables 0 forever.
//  - Opcode 0xD -> err=1 after DECODE; opcode 0xF -> halted=1, pc_we stays 0; rst_n=0 clears both.
//  - rst_n=0 during MEM wait: next cycle mem_req=0, state FETCH; with MC_PERF_CNT_EN,
//    CNT_W=4 run 20 cycles -> cyc_cnt=15 saturated.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared types and opcode helpers for the multi-cycle control FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  // Sequencer states; HALT and ERROR are terminal until reset.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // 0x0-0x7 are register-register ALU operations.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  // 0xC-0xE have no defined behaviour.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_perf_cnt.sv
// ============================================================================
// Module : mc_perf_cnt
// Brief  : Saturating cycle / retired-instruction counter pair.
//          Present only when MC_PERF_CNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MC_PERF_CNT_EN
module mc_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             ret_inc,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  // Both counters stick at all-ones rather than wrapping; run=0 freezes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (run) begin
      if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
      if (ret_inc && (ret_q != '1)) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;

endmodule
`endif

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module : mc_ctrl_fsm
// Brief  : Multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) driving the
//          datapath enables and handshaking with a variable-latency data
//          memory. Optional perf counters under MC_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             eq,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_req,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_e            state_q;
  logic [OPW-1:0]    op_q;
  logic [WAIT_W-1:0] wait_q;

  // Sequencer: opcode is captured in DECODE so EXEC/MEM/WB see a stable copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          op_q    <= opcode;
          state_q <= is_illegal(opcode) ? ST_ERROR : ST_EXEC;
        end
        ST_EXEC: begin
          wait_q <= '0;
          if (op_q == OP_BNE)                        state_q <= ST_FETCH;
          else if ((op_q == OP_LW) || (op_q == OP_SW)) state_q <= ST_MEM;
          else if (op_q == OP_HALT)                  state_q <= ST_HALT;
          else                                       state_q <= ST_WB;
        end
        ST_MEM: begin
          // An ack in the same cycle the wait limit is hit still completes.
          if (mem_ack)                               state_q <= (op_q == OP_LW) ? ST_WB : ST_FETCH;
          else if (wait_q == WAIT_W'(MEM_WAIT_MAX))  state_q <= ST_ERROR;
          else                                       wait_q  <= wait_q + WAIT_W'(1);
        end
        ST_WB:    state_q <= ST_FETCH;
        default:  state_q <= state_q;
      endcase
    end
  end

  // Output decode from the registered state; only BNE's eq and SW's ack
  // completion look at inputs, since both finish in that same cycle.
  always_comb begin
    ir_we      = (state_q == ST_FETCH) && rst_n;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = (state_q == ST_HALT);
    err        = (state_q == ST_ERROR);
    case (state_q)
      ST_EXEC: begin
        alu_src = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI);
        if (op_q == OP_BNE) begin
          pc_we  = 1'b1;
          pc_src = ~eq;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_write = (op_q == OP_SW);
        alu_src   = 1'b1;
        pc_we     = mem_ack && (op_q == OP_SW);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        pc_we      = 1'b1;
        reg_dst    = is_rtype(op_q);
        mem_to_reg = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic ret_inc;

  // A retire is any PC update, plus the cycle that commits to HALT.
  assign ret_inc = pc_we || ((state_q == ST_EXEC) && (op_q == OP_HALT));

  mc_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q != ST_ERROR),
    .ret_inc (ret_inc),
    .cyc_cnt (cyc_cnt),
    .ret_cnt (ret_cnt)
  );
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
// Module : tb_mc_ctrl_fsm
// Brief  : Self-checking bench for mc_ctrl_fsm.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       eq = 1'b0;
  logic       mem_ack = 1'b0;
  logic       ir_we, pc_we, pc_src, reg_dst, reg_write, alu_src;
  logic       mem_req, mem_write, mem_to_reg, halted, err;
  logic [3:0] cyc_cnt, ret_cnt;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.OPW(4), .MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .eq(eq), .mem_ack(mem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src(alu_src), .mem_req(mem_req),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .err(err), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  // {ir_we, pc_we, pc_src, reg_dst, reg_write, alu_src, mem_req, mem_write, mem_to_reg}
  assign outs = {ir_we, pc_we, pc_src, reg_dst, reg_write, alu_src, mem_req, mem_write, mem_to_reg};

  typedef struct {
    logic [3:0] op;
    logic       eq;
    int         ack_after;
    int         exp_cyc;
    logic [8:0] exp_fin;
    int         exp_mem;
    logic       store;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release; returns inside cycle 1 (FETCH).
  task automatic do_reset(input logic check_hold);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();
    if (check_hold) begin
      chk("reset_outs", {23'd0, outs}, 32'd0);
      chk("reset_flags", {30'd0, halted, err}, 32'd0);
      chk("reset_cyc_cnt", {28'd0, cyc_cnt}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
  endtask

  // Runs one instruction from its FETCH cycle until pc_we, acking the
  // memory once ack_after MEM cycles have passed without an ack.
  task automatic run_vec(input int idx);
    vec_t       v;
    int         cycles;
    int         memcnt;
    logic       done;
    logic       store_ok;
    logic       first_ir;
    logic [8:0] fin;
    v        = vecs[idx];
    opcode   = v.op;
    eq       = v.eq;
    cycles   = 0;
    memcnt   = 0;
    done     = 1'b0;
    store_ok = 1'b1;
    first_ir = 1'b0;
    fin      = '0;
    while (!done && cycles < 40) begin
      cycles++;
      mem_ack = mem_req && (memcnt == v.ack_after);
      #1;
      if (cycles == 1) first_ir = ir_we;
      if (mem_req) begin
        memcnt++;
        if (mem_write !== v.store) store_ok = 1'b0;
      end
      if (pc_we) begin
        done = 1'b1;
        fin  = outs;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    chk($sformatf("v%0d_fetch_ir_we", idx), {31'd0, first_ir}, 32'd1);
    chk($sformatf("v%0d_latency", idx), cycles, v.exp_cyc);
    chk($sformatf("v%0d_final_outs", idx), {23'd0, fin}, {23'd0, v.exp_fin});
    chk($sformatf("v%0d_mem_req_cycles", idx), memcnt, v.exp_mem);
    chk($sformatf("v%0d_mem_write", idx), {31'd0, store_ok}, 32'd1);
  endtask

  initial begin
    int         memcnt;
    int         cycles;
    logic [8:0] acc;
    logic       halt_pc;

    vecs[0] = '{op:4'h1, eq:1'b0, ack_after:0, exp_cyc:4, exp_fin:9'b010110000, exp_mem:0, store:1'b0};
    vecs[1] = '{op:4'hA, eq:1'b0, ack_after:0, exp_cyc:4, exp_fin:9'b010010000, exp_mem:0, store:1'b0};
    vecs[2] = '{op:4'hB, eq:1'b0, ack_after:0, exp_cyc:3, exp_fin:9'b011000000, exp_mem:0, store:1'b0};
    vecs[3] = '{op:4'hB, eq:1'b1, ack_after:0, exp_cyc:3, exp_fin:9'b010000000, exp_mem:0, store:1'b0};
    vecs[4] = '{op:4'h8, eq:1'b0, ack_after:3, exp_cyc:8, exp_fin:9'b010010001, exp_mem:4, store:1'b0};
    vecs[5] = '{op:4'h9, eq:1'b0, ack_after:0, exp_cyc:4, exp_fin:9'b010001110, exp_mem:1, store:1'b1};
    vecs[6] = '{op:4'h8, eq:1'b1, ack_after:0, exp_cyc:5, exp_fin:9'b010010001, exp_mem:1, store:1'b0};
    vecs[7] = '{op:4'h7, eq:1'b1, ack_after:0, exp_cyc:4, exp_fin:9'b010110000, exp_mem:0, store:1'b0};

    do_reset(1'b1);
    for (int i = 0; i < 8; i++) run_vec(i);

    // SW with no ack: 16 request cycles, then sticky error with enables off.
    opcode  = 4'h9;
    mem_ack = 1'b0;
    memcnt  = 0;
    cycles  = 0;
    while (!err && cycles < 40) begin
      cycles++;
      if (mem_req) memcnt++;
      tick();
    end
    chk("sw_timeout_mem_req_cycles", memcnt, 16);
    chk("sw_timeout_err", {31'd0, err}, 32'd1);
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = i[0];
      #1;
      acc = acc | outs;
      tick();
    end
    mem_ack = 1'b0;
    chk("error_enables_quiet", {23'd0, acc}, 32'd0);
    chk("error_sticky", {31'd0, err}, 32'd1);

    // Illegal opcode 0xD: error appears the cycle after DECODE.
    do_reset(1'b0);
    opcode = 4'hD;
    tick();
    chk("illegal_decode_no_err", {31'd0, err}, 32'd0);
    tick();
    chk("illegal_err", {31'd0, err}, 32'd1);

    // HALT: halted from cycle 4 onward, PC never written.
    do_reset(1'b0);
    opcode  = 4'hF;
    halt_pc = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      halt_pc = halt_pc | pc_we;
      if (c == 3) chk("halt_not_yet", {31'd0, halted}, 32'd0);
      tick();
    end
    chk("halt_asserted", {31'd0, halted}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      halt_pc = halt_pc | pc_we;
      tick();
    end
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_pc_we_never", {31'd0, halt_pc}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("halt_cleared_by_reset", {30'd0, halted, err}, 32'd0);

    // Reset while LW is waiting in MEM: request dropped, back to FETCH.
    do_reset(1'b0);
    opcode = 4'h8;
    tick();
    tick();
    tick();
    chk("mid_mem_req_high", {31'd0, mem_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_mem_reset_req_drop", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_mem_reset_fetch", {31'd0, ir_we}, 32'd1);

    // Perf counters over 20 cycles of R-type instructions.
    do_reset(1'b0);
    opcode = 4'h2;
    for (int c = 0; c < 20; c++) tick();
`ifdef MC_PERF_CNT_EN
    chk("perf_cyc_saturated", {28'd0, cyc_cnt}, 32'd15);
    chk("perf_ret_count", {28'd0, ret_cnt}, 32'd5);
`else
    chk("perf_cyc_absent", {28'd0, cyc_cnt}, 32'd0);
    chk("perf_ret_absent", {28'd0, ret_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
